nn_digit_uart_tx: RTL

Serialises the classifier's predicted digit onto a UART line for host readout. Sits directly downstream of `top_nn`: each `valid_out` pulse captures the 4-bit `digit_out`. The captured digit is queued in a small FIFO. It is then transmitted as one ASCII character in standard 8N1 framing.

---
 rtl/nn_digit_uart_tx.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/nn_digit_uart_tx.sv
// nn_digit_uart_tx: queues classifier digits and sends each as one ASCII character, 8N1, LSB first.
// Build macro NN_DIGIT_TX_CRLF_EN appends CR and LF after every digit.
module nn_digit_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_in,
  input  logic       valid_in,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ZERO = CW'(0);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [PW:0]   CNT_ZERO  = (PW+1)'(0);
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL  = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  function automatic logic [7:0] encode_digit(input logic [3:0] d);
    logic [7:0] c;
    if (d <= 4'd9) c = {4'h3, d};
    else           c = 8'h3F;
    return c;
  endfunction

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_byte, w_byte_nxt;
  logic          r_tx, r_busy, r_overflow;
  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [PW:0]   r_count, w_count_nxt;
  logic          w_pop, w_push, w_drop, w_full, w_baud_done, w_tx_nxt, w_busy_nxt;
  logic [3:0]    w_head;
`ifdef NN_DIGIT_TX_CRLF_EN
  logic [1:0]    r_char, w_char_nxt;
  logic [3:0]    w_head_next;

  assign w_head_next = r_mem[r_rd_ptr + PTR_ONE];
`endif

  assign w_full      = (r_count == CNT_FULL);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_baud_done = (r_baud == BAUD_LAST);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push      = valid_in && (!w_full || w_pop);
  assign w_drop      = valid_in && w_full && !w_pop;

  // Next-state, baud/bit counters and character selection.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + BAUD_ONE;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_pop       = 1'b0;
`ifdef NN_DIGIT_TX_CRLF_EN
    w_char_nxt  = r_char;
`endif
    case (r_state)
      IDLE: begin
        w_baud_nxt = BAUD_ZERO;
        if (r_count != CNT_ZERO) begin
          w_state_nxt = START;
          w_byte_nxt  = encode_digit(w_head);
`ifdef NN_DIGIT_TX_CRLF_EN
          w_char_nxt  = 2'd0;
`else
          w_pop       = 1'b1;
`endif
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (w_baud_done) begin
          w_state_nxt = DATA;
          w_baud_nxt  = BAUD_ZERO;
          w_bit_nxt   = 3'd0;
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = BAUD_ZERO;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        if (w_baud_done) begin
          w_baud_nxt = BAUD_ZERO;
`ifdef NN_DIGIT_TX_CRLF_EN
          // The digit stays at the FIFO head until its LF has gone out.
          if (r_char != 2'd2) begin
            w_state_nxt = START;
            w_char_nxt  = r_char + 2'd1;
            w_byte_nxt  = (r_char == 2'd0) ? 8'h0D : 8'h0A;
          end else begin
            w_pop      = 1'b1;
            w_char_nxt = 2'd0;
            if (r_count > CNT_ONE) begin
              w_state_nxt = START;
              w_byte_nxt  = encode_digit(w_head_next);
            end else begin
              w_state_nxt = IDLE;
            end
          end
`else
          if (r_count != CNT_ZERO) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
            w_byte_nxt  = encode_digit(w_head);
          end else begin
            w_state_nxt = IDLE;
          end
`endif
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_baud_nxt  = BAUD_ZERO;
      end
    endcase
  end

  // FIFO occupancy and the registered line/busy values derived from next state.
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_byte_nxt[w_bit_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE) || (w_count_nxt != CNT_ZERO);
  end

  // FSM and serialiser registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= BAUD_ZERO;
      r_bit   <= 3'd0;
      r_byte  <= 8'h00;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
`ifdef NN_DIGIT_TX_CRLF_EN
      r_char  <= 2'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
`ifdef NN_DIGIT_TX_CRLF_EN
      r_char  <= w_char_nxt;
`endif
    end
  end

  // Digit queue storage, pointers and the sticky drop flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 4'd0;
      r_rd_ptr   <= PW'(0);
      r_wr_ptr   <= PW'(0);
      r_count    <= CNT_ZERO;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= digit_in;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count    <= w_count_nxt;
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign overflow = r_overflow;
endmodule
